iob_nco_mc: RTL

IOB_NCO_MC -- requirements
Module: iob_nco_mc

---
 rtl/iob_nco_mc_pkg.sv | 21 ++
 rtl/iob_nco_mc_ch.sv | 104 ++++++++++
 rtl/iob_nco_mc.sv | 75 +++++++
 3 files changed

// File: rtl/iob_nco_mc_pkg.sv
// rtl/iob_nco_mc_pkg.sv - shared encodings and helpers for the multi-channel NCO clock generator
// Contents:
//   cfg_sel_e   : register select encodings for cfg_sel_i
//   MIN_PERIOD  : smallest legal PERIOD_INT; below this a channel holds and flags an error
//   ch_width()  : width of the channel index, never less than one bit
package iob_nco_mc_pkg;

    typedef enum logic [1:0] {
        SEL_PERIOD_INT  = 2'd0,
        SEL_PERIOD_FRAC = 2'd1,
        SEL_DUTY        = 2'd2,
        SEL_ENABLE      = 2'd3
    } cfg_sel_e;

    localparam int MIN_PERIOD = 2;

    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/iob_nco_mc_ch.sv
// rtl/iob_nco_mc_ch.sv - one NCO channel: shadow/active config, cycle counter, fraction accumulator
// Ports:
//   clk_i, arst_n_i, cke_i : clock, async active-low reset, clock enable (low = hold)
//   sync_i                 : realign pulse (restart counters, commit shadows)
//   wr_*_i                 : decoded write strobes for this channel
//   wdata_int_i            : PERIOD_INT / DUTY write data
//   wdata_frac_i           : PERIOD_FRAC write data
//   en_bit_i               : ENABLE write data
//   clk_out_o, tick_o      : registered generated clock and end-of-period pulse
//   err_o                  : enabled with an illegal active PERIOD_INT
module iob_nco_mc_ch
    import iob_nco_mc_pkg::*;
#(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 16
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              sync_i,
    input  logic              wr_int_i,
    input  logic              wr_frac_i,
    input  logic              wr_duty_i,
    input  logic              wr_en_i,
    input  logic [INT_W-1:0]  wdata_int_i,
    input  logic [FRAC_W-1:0] wdata_frac_i,
    input  logic              en_bit_i,
    output logic              clk_out_o,
    output logic              tick_o,
    output logic              err_o
);

    logic [INT_W-1:0]  sh_int, act_int;
    logic [FRAC_W-1:0] sh_frac, act_frac;
    logic [INT_W-1:0]  sh_duty, act_duty;
    logic              en;
    logic [INT_W-1:0]  c;
    logic [FRAC_W-1:0] f;
    logic              carry;

    logic              bad_int;
    logic              run;
    logic [INT_W:0]    len;
    logic              period_end;
    logic              commit;
    logic [FRAC_W:0]   frac_sum;

    // One extra bit on len so PERIOD_INT at full scale plus a carry does not wrap.
    assign bad_int    = act_int < INT_W'(MIN_PERIOD);
    assign run        = en && !bad_int;
    assign len        = {1'b0, act_int} + {{INT_W{1'b0}}, carry};
    assign period_end = run && (({1'b0, c} + (INT_W+1)'(1)) == len);
    // A stopped channel (disabled or illegal period) commits every cycle, which is
    // also how a corrected PERIOD_INT gets in and clears the error.
    assign commit     = !run || sync_i || period_end;
    assign frac_sum   = {1'b0, f} + {1'b0, act_frac};
    assign err_o      = en && bad_int;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sh_int    <= '0;
            sh_frac   <= '0;
            sh_duty   <= '0;
            act_int   <= '0;
            act_frac  <= '0;
            act_duty  <= '0;
            en        <= 1'b0;
            c         <= '0;
            f         <= '0;
            carry     <= 1'b0;
            clk_out_o <= 1'b0;
            tick_o    <= 1'b0;
        end else if (cke_i) begin
            if (wr_int_i)  sh_int  <= wdata_int_i;
            if (wr_frac_i) sh_frac <= wdata_frac_i;
            if (wr_duty_i) sh_duty <= wdata_int_i;
            if (wr_en_i)   en      <= en_bit_i;

            // Non-blocking copy picks up the shadow as it was before a coincident write.
            if (commit) begin
                act_int  <= sh_int;
                act_frac <= sh_frac;
                act_duty <= sh_duty;
            end

            if (!run || sync_i) begin
                c     <= '0;
                f     <= '0;
                carry <= 1'b0;
            end else if (period_end) begin
                c     <= '0;
                f     <= frac_sum[FRAC_W-1:0];
                carry <= frac_sum[FRAC_W];
            end else begin
                c     <= c + INT_W'(1);
            end

            // Both outputs describe the counter value of the cycle just finished.
            clk_out_o <= run && (c < act_duty);
            tick_o    <= period_end && !sync_i;
        end
    end

endmodule

// File: rtl/iob_nco_mc.sv
// rtl/iob_nco_mc.sv - multi-channel fractional NCO clock generator: write decode, sync fan-out, ack
// Ports:
//   clk_i, arst_n_i, cke_i          : clock, async active-low reset, clock enable
//   cfg_valid_i, cfg_ch_i,
//   cfg_sel_i, cfg_wdata_i          : config write (channel, register select, LSB-aligned data)
//   cfg_ack_o                       : registered pulse the cycle after an accepted write
//   sync_i                          : realign pulse for all channels
//   clk_out_o, tick_o, err_o        : per-channel generated clock, end-of-period tick, error
module iob_nco_mc
    import iob_nco_mc_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 16,
    parameter int DATA_W = 32,
    localparam int CH_W  = ch_width(N_CH)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              cfg_valid_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [1:0]        cfg_sel_i,
    input  logic [DATA_W-1:0] cfg_wdata_i,
    output logic              cfg_ack_o,
    input  logic              sync_i,
    output logic [N_CH-1:0]   clk_out_o,
    output logic [N_CH-1:0]   tick_o,
    output logic [N_CH-1:0]   err_o
);

    logic     wr_acc;
    cfg_sel_e sel;
    logic     unused_wdata;

    assign wr_acc       = cfg_valid_i && cke_i;
    assign sel          = cfg_sel_e'(cfg_sel_i);
    assign unused_wdata = ^cfg_wdata_i;

    // Every accepted write is acknowledged, including ones aimed at a missing channel.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cfg_ack_o <= 1'b0;
        end else if (cke_i) begin
            cfg_ack_o <= cfg_valid_i;
        end
    end

    // Only indices below N_CH are decoded, so out-of-range writes touch nothing.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic hit;
        assign hit = wr_acc && (cfg_ch_i == CH_W'(i));

        iob_nco_mc_ch #(
            .INT_W (INT_W),
            .FRAC_W(FRAC_W)
        ) u_ch (
            .clk_i       (clk_i),
            .arst_n_i    (arst_n_i),
            .cke_i       (cke_i),
            .sync_i      (sync_i),
            .wr_int_i    (hit && (sel == SEL_PERIOD_INT)),
            .wr_frac_i   (hit && (sel == SEL_PERIOD_FRAC)),
            .wr_duty_i   (hit && (sel == SEL_DUTY)),
            .wr_en_i     (hit && (sel == SEL_ENABLE)),
            .wdata_int_i (cfg_wdata_i[INT_W-1:0]),
            .wdata_frac_i(cfg_wdata_i[FRAC_W-1:0]),
            .en_bit_i    (cfg_wdata_i[0]),
            .clk_out_o   (clk_out_o[i]),
            .tick_o      (tick_o[i]),
            .err_o       (err_o[i])
        );
    end

endmodule
